// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out transmitter.
// Takes one Width-bit word through a valid/ready handshake and emits it as
// Width/ChunkWidth chunks of ChunkWidth bits. The final chunk of every word is
// flagged with out_last_o. A new word may be loaded on the same edge that the
// last chunk of the previous word leaves, so words stream without bubbles.
module piso_serializer #(
  parameter int Width      = 32,
  parameter int ChunkWidth = 8,
  parameter bit MsbFirst   = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [Width-1:0]      in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ChunkWidth-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o
);

  localparam int Beats = Width / ChunkWidth;
  localparam int CntW  = (Beats > 1) ? $clog2(Beats) : 1;

  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // Reject geometries where the word does not split into whole chunks.
  if ((ChunkWidth < 1) || (ChunkWidth > Width) || ((Width % ChunkWidth) != 0)) begin : g_bad_geometry
    $error("piso_serializer: Width must be a positive multiple of ChunkWidth");
  end

  // Chunk that leaves first from a word, according to the chosen order.
  function automatic logic [ChunkWidth-1:0] head_chunk(input logic [Width-1:0] word);
    if (MsbFirst) begin
      return word[Width-1 -: ChunkWidth];
    end
    return word[ChunkWidth-1:0];
  endfunction

  // Word with its head chunk removed, so the next chunk becomes the head.
  function automatic logic [Width-1:0] advance_word(input logic [Width-1:0] word);
    if (Beats == 1) begin
      return '0;
    end
    if (MsbFirst) begin
      return word << ChunkWidth;
    end
    return word >> ChunkWidth;
  endfunction

  logic [0:0]            state_p0;
  logic [Width-1:0]      shift_p0;
  logic [ChunkWidth-1:0] data_p0;
  logic                  last_p0;
  logic [CntW-1:0]       beat_cnt_p0;

  logic            in_fire;
  logic            out_fire;
  logic [CntW-1:0] beat_cnt_nxt;

  // A word is taken when idle, or when the last chunk leaves this very cycle.
  assign in_ready_o   = !srst_i && ((state_p0 == IDLE) ||
                                    ((state_p0 == SEND) && out_ready_i && last_p0));
  assign in_fire      = in_valid_i && in_ready_o;
  assign out_fire     = (state_p0 == SEND) && out_ready_i;
  assign beat_cnt_nxt = beat_cnt_p0 + CntW'(1);

  assign out_valid_o = (state_p0 == SEND);
  assign busy_o      = (state_p0 == SEND);
  assign out_data_o  = data_p0;
  assign out_last_o  = last_p0;

  // --- stage p0: word load, chunk advance and end-of-word bookkeeping ---
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_p0    <= IDLE;
      shift_p0    <= '0;
      data_p0     <= '0;
      last_p0     <= 1'b0;
      beat_cnt_p0 <= '0;
    end else if (in_fire) begin
      state_p0    <= SEND;
      data_p0     <= head_chunk(in_data_i);
      shift_p0    <= advance_word(in_data_i);
      beat_cnt_p0 <= '0;
      last_p0     <= (Beats == 1);
    end else if (out_fire) begin
      if (last_p0) begin
        state_p0 <= IDLE;
        last_p0  <= 1'b0;
      end else begin
        beat_cnt_p0 <= beat_cnt_nxt;
        data_p0     <= head_chunk(shift_p0);
        shift_p0    <= advance_word(shift_p0);
        last_p0     <= (beat_cnt_nxt == LastCnt);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (LSB-first 32/8, MSB-first 32/8,
// single-beat 8/8) driven by directed vectors. A word-level model predicts
// every output each cycle; literal expectations pin the model to hand values.
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst;
  logic        in_valid  [3];
  logic [31:0] in_data   [3];
  logic        out_ready [3];
  logic        o_in_ready[3];
  logic        o_valid   [3];
  logic        o_last    [3];
  logic        o_busy    [3];
  logic [7:0]  o_data    [3];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int P_W   [3] = '{32, 32, 8};
  bit P_MSB [3] = '{1'b0, 1'b1, 1'b0};

  // Model: the word in flight and the index of the chunk being shown.
  bit          m_act  [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] m_word [3] = '{32'h0, 32'h0, 32'h0};
  int          m_k    [3] = '{0, 0, 0};

  piso_serializer #(.Width(32), .ChunkWidth(8), .MsbFirst(1'b0)) u_lsb (
    .clk_i(clk), .srst_i(srst),
    .in_valid_i(in_valid[0]), .in_ready_o(o_in_ready[0]), .in_data_i(in_data[0]),
    .out_valid_o(o_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(o_data[0]),
    .out_last_o(o_last[0]), .busy_o(o_busy[0])
  );

  piso_serializer #(.Width(32), .ChunkWidth(8), .MsbFirst(1'b1)) u_msb (
    .clk_i(clk), .srst_i(srst),
    .in_valid_i(in_valid[1]), .in_ready_o(o_in_ready[1]), .in_data_i(in_data[1]),
    .out_valid_o(o_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(o_data[1]),
    .out_last_o(o_last[1]), .busy_o(o_busy[1])
  );

  piso_serializer #(.Width(8), .ChunkWidth(8), .MsbFirst(1'b0)) u_one (
    .clk_i(clk), .srst_i(srst),
    .in_valid_i(in_valid[2]), .in_ready_o(o_in_ready[2]), .in_data_i(in_data[2][7:0]),
    .out_valid_o(o_valid[2]), .out_ready_i(out_ready[2]), .out_data_o(o_data[2]),
    .out_last_o(o_last[2]), .busy_o(o_busy[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int beats(input int i);
    return P_W[i] / 8;
  endfunction

  function automatic logic exp_ir(input int i);
    return !srst && (!m_act[i] || (out_ready[i] && (m_k[i] == beats(i) - 1)));
  endfunction

  function automatic logic [7:0] exp_chunk(input int i);
    int sh;
    if (P_MSB[i]) sh = P_W[i] - (m_k[i] + 1) * 8;
    else          sh = m_k[i] * 8;
    return 8'(m_word[i] >> sh);
  endfunction

  // Model update at each active edge, from the inputs present at that edge.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (srst) begin
        m_act[i] <= 1'b0;
        m_k[i]   <= 0;
      end else if (in_valid[i] && exp_ir(i)) begin
        m_act[i]  <= 1'b1;
        m_k[i]    <= 0;
        m_word[i] <= (P_W[i] == 32) ? in_data[i] : (in_data[i] & 32'hFF);
      end else if (m_act[i] && out_ready[i]) begin
        if (m_k[i] == beats(i) - 1) m_act[i] <= 1'b0;
        else                        m_k[i]   <= m_k[i] + 1;
      end
    end
  end

  // Compare every instance against the model in the middle of each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model in_ready[%0d]", i), {31'h0, o_in_ready[i]}, {31'h0, exp_ir(i)});
        chk($sformatf("model valid[%0d]", i), {31'h0, o_valid[i]}, {31'h0, m_act[i]});
        chk($sformatf("model busy[%0d]", i), {31'h0, o_busy[i]}, {31'h0, m_act[i]});
        if (m_act[i]) begin
          chk($sformatf("model data[%0d]", i), {24'h0, o_data[i]}, {24'h0, exp_chunk(i)});
          chk($sformatf("model last[%0d]", i), {31'h0, o_last[i]},
              {31'h0, (m_k[i] == beats(i) - 1)});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic see(input int i, input logic [7:0] d, input logic l, input logic ir);
    chk($sformatf("lit valid[%0d]", i), {31'h0, o_valid[i]}, 32'h1);
    chk($sformatf("lit data[%0d]", i), {24'h0, o_data[i]}, {24'h0, d});
    chk($sformatf("lit last[%0d]", i), {31'h0, o_last[i]}, {31'h0, l});
    chk($sformatf("lit in_ready[%0d]", i), {31'h0, o_in_ready[i]}, {31'h0, ir});
  endtask

  task automatic idle_chk(input int i);
    chk($sformatf("lit idle valid[%0d]", i), {31'h0, o_valid[i]}, 32'h0);
    chk($sformatf("lit idle in_ready[%0d]", i), {31'h0, o_in_ready[i]}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    srst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = 32'h0;
      out_ready[i] = 1'b1;
    end
    step();
    step();
    settle();
    // reset state
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst valid[%0d]", i), {31'h0, o_valid[i]}, 32'h0);
      chk($sformatf("rst data[%0d]", i), {24'h0, o_data[i]}, 32'h0);
      chk($sformatf("rst last[%0d]", i), {31'h0, o_last[i]}, 32'h0);
      chk($sformatf("rst busy[%0d]", i), {31'h0, o_busy[i]}, 32'h0);
      chk($sformatf("rst in_ready[%0d]", i), {31'h0, o_in_ready[i]}, 32'h0);
    end
    chk_en = 1'b1;
    srst = 1'b0;
    settle();
    idle_chk(0);

    // LSB-first word
    in_valid[0] = 1'b1; in_data[0] = 32'hA1B2C3D4;
    step(); in_valid[0] = 1'b0; settle();
    see(0, 8'hD4, 1'b0, 1'b0); step(); settle();
    see(0, 8'hC3, 1'b0, 1'b0); step(); settle();
    see(0, 8'hB2, 1'b0, 1'b0); step(); settle();
    see(0, 8'hA1, 1'b1, 1'b1); step(); settle();
    idle_chk(0);

    // MSB-first word
    in_valid[1] = 1'b1; in_data[1] = 32'hA1B2C3D4;
    step(); in_valid[1] = 1'b0; settle();
    see(1, 8'hA1, 1'b0, 1'b0); step(); settle();
    see(1, 8'hB2, 1'b0, 1'b0); step(); settle();
    see(1, 8'hC3, 1'b0, 1'b0); step(); settle();
    see(1, 8'hD4, 1'b1, 1'b1); step(); settle();
    idle_chk(1);

    // back-to-back words with in_valid held
    in_valid[0] = 1'b1; in_data[0] = 32'h11223344;
    step(); in_data[0] = 32'h55667788; settle();
    see(0, 8'h44, 1'b0, 1'b0); step(); settle();
    see(0, 8'h33, 1'b0, 1'b0); step(); settle();
    see(0, 8'h22, 1'b0, 1'b0); step(); settle();
    see(0, 8'h11, 1'b1, 1'b1); step(); in_valid[0] = 1'b0; settle();
    see(0, 8'h88, 1'b0, 1'b0); step(); settle();
    see(0, 8'h77, 1'b0, 1'b0); step(); settle();
    see(0, 8'h66, 1'b0, 1'b0); step(); settle();
    see(0, 8'h55, 1'b1, 1'b1); step(); settle();
    idle_chk(0);

    // backpressure on chunk 1
    in_valid[0] = 1'b1; in_data[0] = 32'hA1B2C3D4;
    step(); in_valid[0] = 1'b0; settle();
    see(0, 8'hD4, 1'b0, 1'b0); step(); settle();
    see(0, 8'hC3, 1'b0, 1'b0);
    out_ready[0] = 1'b0; settle();
    for (int r = 0; r < 3; r++) begin
      see(0, 8'hC3, 1'b0, 1'b0); step(); settle();
    end
    see(0, 8'hC3, 1'b0, 1'b0);
    out_ready[0] = 1'b1; settle();
    see(0, 8'hC3, 1'b0, 1'b0); step(); settle();
    see(0, 8'hB2, 1'b0, 1'b0); step(); settle();
    see(0, 8'hA1, 1'b1, 1'b1); step(); settle();
    idle_chk(0);

    // reset in the middle of a word
    in_valid[0] = 1'b1; in_data[0] = 32'hA1B2C3D4;
    step(); in_valid[0] = 1'b0; settle();
    see(0, 8'hD4, 1'b0, 1'b0); step(); settle();
    see(0, 8'hC3, 1'b0, 1'b0); step(); settle();
    see(0, 8'hB2, 1'b0, 1'b0);
    srst = 1'b1; settle();
    chk("mid rst in_ready", {31'h0, o_in_ready[0]}, 32'h0);
    step(); srst = 1'b0; settle();
    chk("post rst valid", {31'h0, o_valid[0]}, 32'h0);
    chk("post rst data", {24'h0, o_data[0]}, 32'h0);
    chk("post rst last", {31'h0, o_last[0]}, 32'h0);
    chk("post rst busy", {31'h0, o_busy[0]}, 32'h0);
    chk("post rst in_ready", {31'h0, o_in_ready[0]}, 32'h1);
    in_valid[0] = 1'b1; in_data[0] = 32'h0000BEEF;
    step(); in_valid[0] = 1'b0; settle();
    see(0, 8'hEF, 1'b0, 1'b0); step(); settle();
    see(0, 8'hBE, 1'b0, 1'b0); step(); settle();
    see(0, 8'h00, 1'b0, 1'b0); step(); settle();
    see(0, 8'h00, 1'b1, 1'b1); step(); settle();
    idle_chk(0);

    // single-beat geometry
    in_valid[2] = 1'b1; in_data[2] = 32'h5A;
    step(); in_valid[2] = 1'b0; settle();
    see(2, 8'h5A, 1'b1, 1'b1); step(); settle();
    idle_chk(2);
    in_valid[2] = 1'b1; in_data[2] = 32'h01;
    step(); in_data[2] = 32'h02; settle();
    see(2, 8'h01, 1'b1, 1'b1); step(); in_data[2] = 32'h03; settle();
    see(2, 8'h02, 1'b1, 1'b1); step(); in_valid[2] = 1'b0; settle();
    see(2, 8'h03, 1'b1, 1'b1); step(); settle();
    idle_chk(2);

    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter with valid/ready handshakes on both sides.
- Accepts one Width-bit word upstream and emits it downstream as Width/ChunkWidth chunks of ChunkWidth bits, flagging the final chunk with out_last_o.
- Acts as the transmit end of a chunked word stream. It feeds narrow buses such as a byte-wide link or the pixel/weight loaders; the matching deserializer on the far side rebuilds the words.

Parameters:
- Width, 32, bits per input word; must be an integer multiple of ChunkWidth (elaboration error otherwise).
- ChunkWidth, 8, bits per output beat; must be at least 1 and at most Width.
- MsbFirst, 0, 0 = least-significant chunk first; 1 = most-significant chunk first.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- srst_i  input  1  synchronous reset, active-high.
- in_valid_i  input  1  upstream word valid.
- in_ready_o  output  1  serializer can accept a word this cycle.
- in_data_i  input  Width  upstream word.
- out_valid_o  output  1  out_data_o holds a valid chunk.
- out_ready_i  input  1  downstream accepts the chunk this cycle.
- out_data_o  output  ChunkWidth  current chunk.
- out_last_o  output  1  current chunk is the final chunk of its word.
- busy_o  output  1  a word is held (equal to out_valid_o).

Behaviour:
- Beats = Width/ChunkWidth. beat_cnt is clog2(Beats) bits wide, minimum 1 bit.
- Reset: while srst_i is high, the next edge sets:
  - out_valid_o=0, out_data_o=0, out_last_o=0, busy_o=0, beat_cnt=0, shift register=0.
  - srst_i takes priority over every other input.
  - in_ready_o is forced to 0 during any cycle srst_i is high.
- Reset mid-word: remaining chunks are discarded, with no partial completion or out_last_o. The first cycle after reset shows in_ready_o=1.
- States:
  - IDLE: out_valid_o=0.
  - SEND: out_valid_o=1.
- Input handshake: the word transfers on a rising edge where in_valid_i && in_ready_o.
- in_ready_o = !srst_i && (IDLE || (SEND && out_ready_i && out_last_o)). This is a combinational path from out_ready_i to in_ready_o and is accepted.
- IDLE -> SEND on input transfer:
  - Latency is 1 cycle: chunk 0 appears on out_data_o in the cycle after the accepting edge.
  - beat_cnt=0.
  - out_last_o = (Beats==1).
- Chunk order:
  - MsbFirst=0: chunk k = in_data[k*ChunkWidth +: ChunkWidth].
  - MsbFirst=1: chunk k = in_data[Width-1-k*ChunkWidth -: ChunkWidth].
- Output handshake:
  - A chunk transfers on an edge where out_valid_o && out_ready_i.
  - While out_valid_o && !out_ready_i, out_data_o and out_last_o stay bit-stable.
  - out_valid_o never drops without a transfer, except on reset.
- SEND, transfer, not last: beat_cnt increments; the next chunk is presented the following cycle; out_last_o = (beat_cnt_next==Beats-1).
- SEND, transfer of last chunk:
  - If in_valid_i in the same cycle: load the new word and stay in SEND with beat_cnt=0. No bubble between words.
  - Otherwise go to IDLE: out_valid_o=0, out_last_o=0. out_data_o may hold its old value, but the bench must not check it while invalid.
- in_valid_i while SEND and not on a last-chunk transfer: in_ready_o=0, so the word is not taken; upstream must hold it.
- out_data_o, out_valid_o and out_last_o are registered outputs; none is derived combinationally from inputs.
- Throughput: one chunk per cycle under continuous out_ready_i; Beats cycles per word.

Test Plan:
- Defaults; after reset, in 0xA1B2C3D4 with out_ready_i=1 -> out_data_o = D4, C3, B2, A1 on 4 consecutive cycles starting 1 cycle after accept; out_last_o only on A1; then out_valid_o=0 and in_ready_o=1.
- MsbFirst=1, same word -> A1, B2, C3, D4, out_last_o on D4.
- Back-to-back words 0x11223344 and 0x55667788, in_valid_i held, out_ready_i=1 -> 8 contiguous beats 44, 33, 22, 11, 88, 77, 66, 55. out_last_o on 11 and 55. in_ready_o pulses only on the two last-beat cycles (plus the first IDLE accept).
- Backpressure: out_ready_i low for 3 cycles while chunk 1 (0xC3) is shown -> out_data_o=C3 and out_valid_o=1 stable for all 3 cycles, then it completes normally; in_ready_o=0 throughout.
- Reset mid-word: assert srst_i 1 cycle after chunk 1 is accepted -> next cycle out_valid_o=0, out_data_o=0, out_last_o=0. The following word 0x0000BEEF emits EF, BE, 00, 00.
- Width=8, ChunkWidth=8 (Beats=1): in 0x5A -> a single beat 0x5A with out_last_o=1; back-to-back words stream at one per cycle.
